// File: rtl/cla12_acc_unit.sv
// cla12_acc_unit: framed 12-bit streaming accumulator driving a carry-lookahead adder,
// with sticky carry/borrow, signed overflow and saturating beat count on a valid/ready result port.
module cla12_acc_unit #(
   parameter int WIDTH = 12,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:1]   in_data,
   input  logic             in_sub,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:1]   out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [CNT_W:1]   out_count
);
   localparam int NG = WIDTH / 4;
   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;
   logic [0:0]     r_state;
   logic [WIDTH:1] r_acc;
   logic           r_carry;
   logic           r_ovf;
   logic [CNT_W:1] r_cnt;
   logic [WIDTH:1] w_b, w_g, w_p, w_s;
   logic [WIDTH+1:1] w_c;
   logic [NG:0]    w_gc;
   logic [NG-1:0]  w_gg, w_gp;
   logic           w_beat, w_cev, w_oev;
   assign w_b = in_sub ? ~in_data : in_data;
   assign w_g = r_acc & w_b;
   assign w_p = r_acc ^ w_b;
   // 4-bit lookahead groups chained by group generate/propagate
   always_comb begin
      w_gg = '0;
      w_gp = '0;
      w_c  = '0;
      w_gc = '0;
      w_gc[0] = in_sub;
      for (int k = 0; k < NG; k++) begin
         w_gg[k] = w_g[4*k+4] | (w_p[4*k+4] & w_g[4*k+3]) | (w_p[4*k+4] & w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+4] & w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1]);
         w_gp[k] = &w_p[4*k+1 +: 4];
         w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
         w_c[4*k+1] = w_gc[k];
         w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_gc[k]);
         w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1]) | (w_p[4*k+2] & w_p[4*k+1] & w_gc[k]);
         w_c[4*k+4] = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2]) | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_gc[k]);
      end
      w_c[WIDTH+1] = w_gc[NG];
   end
   assign w_s    = w_p ^ w_c[WIDTH:1];
   assign w_cev  = w_c[WIDTH+1] ^ in_sub;
   assign w_oev  = (r_acc[WIDTH] == w_b[WIDTH]) && (w_s[WIDTH] != r_acc[WIDTH]);
   assign w_beat = in_valid && (r_state == ST_ACC);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_ACC;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else if (r_state == ST_HOLD) begin
         if (out_ready) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
         end
      end else if (w_beat) begin
         r_acc   <= w_s;
         r_carry <= r_carry | w_cev;
         r_ovf   <= r_ovf | w_oev;
         r_cnt   <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
         if (in_last) r_state <= ST_HOLD;
      end
   end
   assign in_ready  = (r_state == ST_ACC);
   assign out_valid = (r_state == ST_HOLD);
   assign out_sum   = r_acc;
   assign out_carry = r_carry;
   assign out_ovf   = r_ovf;
   assign out_count = r_cnt;
endmodule

// File: tb/tb_cla12_acc_unit.sv
// tb_cla12_acc_unit: queue scoreboard for cla12_acc_unit against an integer-arithmetic frame model.
module tb_cla12_acc_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic [12:1] in_data = '0;
   logic        in_ready, out_valid, out_carry, out_ovf;
   logic [12:1] out_sum;
   logic [8:1]  out_count;
   logic [21:0] q[$];
   int n_chk = 0, n_fail = 0;
   int m_acc = 0, m_n = 0, or_mode = 1;
   bit m_c = 0, m_o = 0;

   cla12_acc_unit #(.WIDTH(12), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sub(in_sub), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sgn(input int v);
      return v >= 2048 ? v - 4096 : v;
   endfunction

   task automatic model_clear();
      m_acc = 0; m_n = 0; m_c = 0; m_o = 0;
   endtask

   task automatic model_beat(input int d, input bit sub, input bit last);
      int r, sr;
      r  = sub ? m_acc - d : m_acc + d;
      sr = sub ? sgn(m_acc) - sgn(d) : sgn(m_acc) + sgn(d);
      if (sub ? (m_acc < d) : (r > 4095)) m_c = 1;
      if (sr > 2047 || sr < -2048) m_o = 1;
      m_acc = (r + 4096) % 4096;
      m_n   = m_n < 255 ? m_n + 1 : 255;
      if (last) begin
         q.push_back({12'(m_acc), m_c, m_o, 8'(m_n)});
         model_clear();
      end
   endtask

   task automatic beat(input int d, input bit sub, input bit last);
      int  t = 0;
      bit  ok = 0;
      in_valid = 1'b1; in_data = 12'(d); in_sub = sub; in_last = last;
      while (!ok && t < 60) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      n_chk++;
      if (ok) model_beat(d, sub, last);
      else begin
         n_fail++;
         $display("FAIL beat_accept: in_ready got 0 expected 1 within %0d cycles", t);
      end
      in_valid = 1'b0; in_data = 12'($urandom); in_sub = 1'($urandom); in_last = 1'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("drain_queue_size", 64'(q.size()), 64'd0);
      q.delete();
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = (or_mode == 2) ? ($urandom_range(0, 2) == 0) : (or_mode == 1);
   end

   // scoreboard monitor: handshake state follows the queue, head entry must be held while valid
   always @(negedge clk) begin
      logic ev;
      ev = (q.size() != 0);
      chk("valid_ready", {62'd0, out_valid, in_ready}, {62'd0, ev, !ev});
      if (ev) begin
         chk("frame_result", {42'd0, out_sum, out_carry, out_ovf, out_count}, {42'd0, q[0]});
         if (out_ready) void'(q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("reset_outputs", {41'd0, in_ready, out_valid, out_sum, out_carry, out_ovf, out_count},
          {41'd0, 1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 8'h0});
      idle(2);
      rst = 1'b0;
      beat(100, 0, 0); beat(200, 0, 0); beat(300, 0, 1);
      beat(12'hFFF, 0, 0); beat(1, 0, 1);
      beat(12'h7FF, 0, 0); beat(1, 0, 1);
      beat(5, 0, 0); beat(7, 1, 1);
      beat(1, 1, 1);
      beat(0, 1, 1);
      beat(12'h800, 1, 1);
      drain();
      or_mode = 0;
      beat(11, 0, 0); beat(22, 1, 0); beat(33, 0, 1);
      idle(4);
      or_mode = 1;
      beat(9, 0, 1);
      drain();
      beat(50, 0, 0); beat(50, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("midframe_reset", {41'd0, in_ready, out_valid, out_sum, out_carry, out_ovf, out_count},
          {41'd0, 1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 8'h0});
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      beat(3, 0, 1);
      drain();
      for (int i = 1; i <= 260; i++) beat(int'($urandom_range(0, 4095)), 1'($urandom), i == 260);
      drain();
      or_mode = 2;
      for (int f = 0; f < 30; f++) begin
         int len;
         len = $urandom_range(1, 6);
         for (int i = 1; i <= len; i++) begin
            beat(int'($urandom_range(0, 4095)), 1'($urandom), i == len);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      drain();
      or_mode = 1;
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
